maze_render: RTL
================

# maze_render

Pixel-pipeline stage directly downstream of the VGA sync/position generator. It turns the per-pixel maze cell coordinates into 12-bit RGB by reading a 1-bit-per-cell maze RAM, and overlays the player and goal cells. It also owns the player position, applying at most one move per frame during vertical blank after a wall check through the same RAM port. Sync and visible signals are delayed to stay aligned with the pixel data.

## Interface
- MAZE_W, 40, maze width in cells (640/16 at pixel size 16)
- MAZE_H, 30, maze height in cells
- START_X, 1 / START_Y, 1: player reset cell
- GOAL_X, 38 / GOAL_Y, 28: goal cell
- halfClk  in  1  25 MHz pixel clock
- i_Rst  in  1  reset, asynchronous, active-low; clock halfClk
- i_XPos  in  6  current cell column from sync stage
- i_YPos  in  5  current cell row from sync stage
- i_Visible  in  1  1 = active display pixel
- i_hsync, i_vsync  in  1 each  sync from sync stage, active-low
- i_fDrawDone  in  1  1-cycle pulse on last visible pixel (639,479)
- i_Move  in  4  {up,down,left,right} request pulses, any cycle
- o_RamAddr  out  11  {row[4:0], col[5:0]} maze RAM read address
- i_RamData  in  1  wall bit (1 = wall), valid 1 cycle after address
- o_R, o_G, o_B  out  4 each  pixel colour
- o_hsync, o_vsync  out  1 each  sync delayed 2 cycles
- o_Win  out  1  sticky, player has reached goal

## Operation
- Render path: stage 0 drives o_RamAddr = {i_YPos,i_XPos} when FSM is IDLE; stage 1 holds RAM output plus delayed cell coords and visible; stage 2 registers colour.
- Colour priority at stage 2: not visible -> 000; player cell -> F00; goal cell -> 0F0; wall -> FFF; else 000.
- Move latching: pending[3:0] |= i_Move every cycle; cleared in EVAL; i_Move bits arriving in the EVAL cycle are kept.
- Direction select from pending: up > down > left > right; target = player ± 1 in one axis.
- FSM states IDLE, CHECK, EVAL:
  - IDLE -> CHECK on i_fDrawDone & pending≠0 & !o_Win & target in bounds.
  - IDLE, i_fDrawDone & pending≠0 & target out of bounds (col 0 left, col MAZE_W-1 right, row 0 up, row MAZE_H-1 down): clear pending, stay IDLE.
  - CHECK: o_RamAddr = target; -> EVAL.
  - EVAL: if i_RamData==0, player <= target; clear pending; -> IDLE.
- o_Win set in the cycle after player == goal; once set, pending is ignored and never starts a move.
- Reset: player = (START_X,START_Y), pending = 0, FSM = IDLE, o_Win = 0, all pipeline regs 0, o_R/G/B = 0, o_hsync = o_vsync = 1.

## Timing
- Pixel latency: 2 cycles from i_XPos/i_YPos/i_Visible/i_hsync/i_vsync to o_R/G/B/o_hsync/o_vsync.
- Move: i_fDrawDone at cycle t -> CHECK at t+1 -> EVAL at t+2 -> new position registered at end of t+2 and used from the next frame's first visible pixel.
- CHECK/EVAL fall in vertical blank, so address steal never corrupts visible pixels.
- At most one move per frame; extra requests stay pending until the next frame.
- i_Rst assertion mid-CHECK/EVAL aborts the move immediately; no position update.

## Structure
- maze_pkg: MAZE_W/MAZE_H defaults, colour constants (C_WALL, C_PATH, C_PLAYER, C_GOAL), FSM state enum, direction bit indices.
- No sub-module; priority encoder and bounds check inline.

## Test plan
- Reset, blank RAM, one frame -> player cell (1,1) red, goal (38,28) green, others black; outputs 2 cycles behind inputs.
- Pending right, RAM(1,2)=0, i_fDrawDone -> CHECK addr {5'd1,6'd2}, player (2,1) after EVAL.
- Pending right, RAM(1,2)=1 -> player stays (1,1), pending cleared.
- Pending up+left at (1,0)... player at row 0, up+left -> up rejected as out of bounds, no RAM read, pending cleared.
- Player moved onto (38,28) -> o_Win=1 next cycle; later moves ignored.
- i_Rst low during EVAL -> player (1,1), FSM IDLE, o_R/G/B=0, o_hsync=o_vsync=1.

Source files
------------

// File: rtl/maze_render_pkg.sv
// rtl/maze_render_pkg.sv - shared constants, colours and FSM states for the maze renderer
package maze_render_pkg;

  localparam int MAZE_W_DEF = 40;
  localparam int MAZE_H_DEF = 30;

  localparam logic [11:0] C_BLANK  = 12'h000;
  localparam logic [11:0] C_WALL   = 12'hFFF;
  localparam logic [11:0] C_PATH   = 12'h000;
  localparam logic [11:0] C_PLAYER = 12'hF00;
  localparam logic [11:0] C_GOAL   = 12'h0F0;

  // Bit positions inside the {up,down,left,right} move vector
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_EVAL  = 2'd2
  } state_t;

  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/maze_render_if.sv
// rtl/maze_render_if.sv - maze RAM read port (address out, wall bit back one cycle later)
interface maze_render_if;
  logic [10:0] ram_addr;
  logic        ram_data;

  modport master (output ram_addr, input ram_data);
  modport slave  (input ram_addr, output ram_data);
endinterface

// File: rtl/maze_render.sv
// rtl/maze_render.sv - maze pixel colouring pipeline plus per-frame player move FSM
module maze_render
  import maze_render_pkg::*;
#(
  parameter int MAZE_W  = MAZE_W_DEF,
  parameter int MAZE_H  = MAZE_H_DEF,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 38,
  parameter int GOAL_Y  = 28
) (
  input  logic               halfClk,
  input  logic               i_Rst,
  input  logic [5:0]         i_XPos,
  input  logic [4:0]         i_YPos,
  input  logic               i_Visible,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_fDrawDone,
  input  logic [3:0]         i_Move,
  maze_render_if.master      ram,
  output logic [3:0]         o_R,
  output logic [3:0]         o_G,
  output logic [3:0]         o_B,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_Win
);

  localparam logic [5:0] COL_LAST  = 6'(MAZE_W - 1);
  localparam logic [4:0] ROW_LAST  = 5'(MAZE_H - 1);
  localparam logic [5:0] START_COL = 6'(START_X);
  localparam logic [4:0] START_ROW = 5'(START_Y);
  localparam logic [5:0] GOAL_COL  = 6'(GOAL_X);
  localparam logic [4:0] GOAL_ROW  = 5'(GOAL_Y);

  state_t      state_q, state_d;
  logic [5:0]  px_q, px_d;
  logic [4:0]  py_q, py_d;
  logic [3:0]  pending_q, pending_d;
  logic [5:0]  tx_q, tx_d;
  logic [4:0]  ty_q, ty_d;
  logic        win_q, win_d;

  logic [5:0]  s1_x_q, s1_x_d;
  logic [4:0]  s1_y_q, s1_y_d;
  logic        s1_vis_q, s1_vis_d;
  logic        s1_hs_q, s1_hs_d;
  logic        s1_vs_q, s1_vs_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  logic [5:0]  tgt_x;
  logic [4:0]  tgt_y;
  logic        tgt_ok;

  // Highest-priority pending direction and whether its neighbour lies inside the maze
  always_comb begin
    tgt_x  = px_q;
    tgt_y  = py_q;
    tgt_ok = 1'b0;
    if (pending_q[DIR_UP]) begin
      tgt_y  = py_q - 5'd1;
      tgt_ok = (py_q != 5'd0);
    end else if (pending_q[DIR_DOWN]) begin
      tgt_y  = py_q + 5'd1;
      tgt_ok = (py_q != ROW_LAST);
    end else if (pending_q[DIR_LEFT]) begin
      tgt_x  = px_q - 6'd1;
      tgt_ok = (px_q != 6'd0);
    end else if (pending_q[DIR_RIGHT]) begin
      tgt_x  = px_q + 6'd1;
      tgt_ok = (px_q != COL_LAST);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | i_Move;
    px_d      = px_q;
    py_d      = py_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    win_d     = win_q | ((px_q == GOAL_COL) && (py_q == GOAL_ROW));
    case (state_q)
      ST_IDLE: begin
        if (i_fDrawDone && (pending_q != 4'd0) && !win_q) begin
          if (tgt_ok) begin
            state_d = ST_CHECK;
            tx_d    = tgt_x;
            ty_d    = tgt_y;
          end else begin
            pending_d = i_Move;
          end
        end
      end
      ST_CHECK: state_d = ST_EVAL;
      ST_EVAL: begin
        if (!ram.ram_data) begin
          px_d = tx_q;
          py_d = ty_q;
        end
        pending_d = i_Move;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The RAM port is borrowed for the wall lookup only in CHECK, which lands in vertical blank
  always_comb begin
    ram.ram_addr = cell_addr(i_YPos, i_XPos);
    if (state_q == ST_CHECK) ram.ram_addr = cell_addr(ty_q, tx_q);
  end

  always_comb begin
    s1_x_d   = i_XPos;
    s1_y_d   = i_YPos;
    s1_vis_d = i_Visible;
    s1_hs_d  = i_hsync;
    s1_vs_d  = i_vsync;
    hs_d     = s1_hs_q;
    vs_d     = s1_vs_q;
    rgb_d    = C_BLANK;
    if (!s1_vis_q)                                rgb_d = C_BLANK;
    else if ((s1_x_q == px_q) && (s1_y_q == py_q)) rgb_d = C_PLAYER;
    else if ((s1_x_q == GOAL_COL) && (s1_y_q == GOAL_ROW)) rgb_d = C_GOAL;
    else if (ram.ram_data)                        rgb_d = C_WALL;
    else                                          rgb_d = C_PATH;
  end

  always_ff @(posedge halfClk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= ST_IDLE;
      px_q      <= START_COL;
      py_q      <= START_ROW;
      pending_q <= 4'd0;
      tx_q      <= 6'd0;
      ty_q      <= 5'd0;
      win_q     <= 1'b0;
      s1_x_q    <= 6'd0;
      s1_y_q    <= 5'd0;
      s1_vis_q  <= 1'b0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      rgb_q     <= 12'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      win_q     <= win_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      s1_vis_q  <= s1_vis_d;
      s1_hs_q   <= s1_hs_d;
      s1_vs_q   <= s1_vs_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign o_R     = rgb_q[11:8];
  assign o_G     = rgb_q[7:4];
  assign o_B     = rgb_q[3:0];
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_Win   = win_q;

endmodule
